// File: rtl/vector_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : vector_arbiter_if
// Brief    : Consumer request/grant and shared vector buffer bundle for
//            vector_arbiter.
// Revision : 1.0
// ============================================================================
interface vector_arbiter_if;
    logic [1:0] req;
    logic       buf_req;
    logic [7:0] buf_vector;
    logic       buf_valid;
    logic [1:0] gnt;
    logic [7:0] vec_out;
    logic [1:0] done;
    logic       err;

    // Arbiter side
    modport master (
        input  req,
        input  buf_vector,
        input  buf_valid,
        output buf_req,
        output gnt,
        output vec_out,
        output done,
        output err
    );

    // Consumer / buffer side
    modport slave (
        output req,
        output buf_vector,
        output buf_valid,
        input  buf_req,
        input  gnt,
        input  vec_out,
        input  done,
        input  err
    );
endinterface
`default_nettype wire

// File: rtl/vector_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : vector_arbiter
// Brief    : Round-robin arbiter giving two consumers access to a shared
//            vector buffer. Optional REQ-state abort via VECTOR_ARB_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
module vector_arbiter #(
    parameter int TIMEOUT = 64
) (
    input wire logic         clk,
    input wire logic         reset,
    vector_arbiter_if.master bus
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_DELIVER = 2'd2
    } state_t;

    state_t     r_state;
    logic [1:0] r_gnt;
    logic       r_buf_req;
    logic [7:0] r_vec_out;
    logic [1:0] r_done;
    logic       r_last;
    logic [1:0] w_pick;

`ifdef VECTOR_ARB_TIMEOUT_EN
    localparam logic [7:0] c_timeout = 8'(TIMEOUT);
    logic [7:0] r_cnt;
    logic [7:0] w_cnt_next;
    logic       r_err;

    assign w_cnt_next = r_cnt + 8'd1;
    assign bus.err    = r_err;
`else
    assign bus.err    = 1'b0;
`endif

    // r_last holds the index of the consumer granted most recently
    always_comb begin
        w_pick = 2'b00;
        case (bus.req)
            2'b01:   w_pick = 2'b01;
            2'b10:   w_pick = 2'b10;
            2'b11:   w_pick = r_last ? 2'b01 : 2'b10;
            default: w_pick = 2'b00;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_gnt     <= 2'b00;
            r_buf_req <= 1'b0;
            r_vec_out <= 8'h00;
            r_done    <= 2'b00;
            r_last    <= 1'b1;
`ifdef VECTOR_ARB_TIMEOUT_EN
            r_cnt     <= 8'd0;
            r_err     <= 1'b0;
`endif
        end else begin
            r_done <= 2'b00;
`ifdef VECTOR_ARB_TIMEOUT_EN
            r_err  <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (bus.req != 2'b00) begin
                        r_gnt     <= w_pick;
                        r_last    <= w_pick[1];
                        r_buf_req <= 1'b1;
                        r_state   <= S_REQ;
`ifdef VECTOR_ARB_TIMEOUT_EN
                        r_cnt     <= 8'd0;
`endif
                    end
                end
                S_REQ: begin
                    if (bus.buf_valid) begin
                        r_vec_out <= bus.buf_vector;
                        r_done    <= r_gnt;
                        r_buf_req <= 1'b0;
                        r_state   <= S_DELIVER;
                    end
`ifdef VECTOR_ARB_TIMEOUT_EN
                    // Abort on the edge the in-REQ cycle count would hit TIMEOUT
                    else if (w_cnt_next == c_timeout) begin
                        r_buf_req <= 1'b0;
                        r_gnt     <= 2'b00;
                        r_err     <= 1'b1;
                        r_state   <= S_IDLE;
                    end else begin
                        r_cnt     <= w_cnt_next;
                    end
`endif
                end
                S_DELIVER: begin
                    r_gnt   <= 2'b00;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_gnt     <= 2'b00;
                    r_buf_req <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.gnt     = r_gnt;
    assign bus.buf_req = r_buf_req;
    assign bus.vec_out = r_vec_out;
    assign bus.done    = r_done;

endmodule
`default_nettype wire

// File: tb/tb_vector_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_vector_arbiter
// Brief    : Directed self-checking bench for vector_arbiter.
// Revision : 1.0
// ============================================================================
module tb_vector_arbiter;

`ifdef VECTOR_ARB_TIMEOUT_EN
    localparam int TMO = 5;
`else
    localparam int TMO = 64;
`endif

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    vector_arbiter_if bus ();

    vector_arbiter #(.TIMEOUT(TMO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed no_finish expected finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        reset          = 1'b0;
        bus.req        = 2'b00;
        bus.buf_vector = 8'h00;
        bus.buf_valid  = 1'b0;
        step();
        step();
        chk("rst_gnt",     32'(bus.gnt),     32'h0);
        chk("rst_buf_req", 32'(bus.buf_req), 32'h0);
        chk("rst_done",    32'(bus.done),    32'h0);
        chk("rst_err",     32'(bus.err),     32'h0);
        chk("rst_vec_out", 32'(bus.vec_out), 32'h0);
        reset = 1'b1;

        // Idle with no request
        step();
        chk("idle_gnt",     32'(bus.gnt),     32'h0);
        chk("idle_buf_req", 32'(bus.buf_req), 32'h0);

        // Both consumers requesting: alternate starting with consumer 0
        bus.req       = 2'b11;
        bus.buf_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.buf_vector = 8'(8'h10 + i);
            step();
            chk("rr_gnt",     32'(bus.gnt),     (i % 2 == 0) ? 32'h1 : 32'h2);
            chk("rr_buf_req", 32'(bus.buf_req), 32'h1);
            step();
            chk("rr_done",    32'(bus.done),    (i % 2 == 0) ? 32'h1 : 32'h2);
            chk("rr_vec",     32'(bus.vec_out), 32'(8'h10 + i));
            step();
            chk("rr_done_off", 32'(bus.done),   32'h0);
            chk("rr_idle_gnt", 32'(bus.gnt),    32'h0);
        end
        bus.req = 2'b00;
        step();

        // Single consumer 0, buffer already valid
        bus.req        = 2'b01;
        bus.buf_vector = 8'hA5;
        step();
        chk("s0_gnt",     32'(bus.gnt),     32'h1);
        chk("s0_done0",   32'(bus.done),    32'h0);
        step();
        chk("s0_done",    32'(bus.done),    32'h1);
        chk("s0_vec",     32'(bus.vec_out), 32'hA5);
        chk("s0_buf_req", 32'(bus.buf_req), 32'h0);
        bus.req = 2'b00;
        step();
        chk("s0_idle_gnt", 32'(bus.gnt),    32'h0);
        chk("s0_done_off", 32'(bus.done),   32'h0);
        // buf_valid in IDLE is ignored and vec_out holds
        bus.buf_vector = 8'h77;
        step();
        chk("ign_done", 32'(bus.done),    32'h0);
        chk("ign_vec",  32'(bus.vec_out), 32'hA5);

        // Consumer 1 with delayed buffer; req switches during the wait
        bus.buf_valid  = 1'b0;
        bus.buf_vector = 8'h3C;
        bus.req        = 2'b10;
        step();
        chk("dly_gnt", 32'(bus.gnt), 32'h2);
        bus.req = 2'b01;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("dly_buf_req", 32'(bus.buf_req), 32'h1);
            chk("dly_gnt_hold", 32'(bus.gnt),   32'h2);
            chk("dly_done",    32'(bus.done),    32'h0);
        end
        bus.buf_valid = 1'b1;
        step();
        chk("dly_done_pulse", 32'(bus.done),    32'h2);
        chk("dly_vec",        32'(bus.vec_out), 32'h3C);
        step();
        chk("dly_idle", 32'(bus.gnt), 32'h0);
        bus.buf_vector = 8'h5A;
        step();
        chk("wait_gnt", 32'(bus.gnt), 32'h1);
        step();
        chk("wait_done", 32'(bus.done),    32'h1);
        chk("wait_vec",  32'(bus.vec_out), 32'h5A);
        bus.req = 2'b00;
        step();

        // Asynchronous reset in REQ
        bus.buf_valid = 1'b0;
        bus.req       = 2'b01;
        step();
        chk("ar_buf_req_pre", 32'(bus.buf_req), 32'h1);
        #2;
        reset = 1'b0;
        #1;
        chk("ar_buf_req", 32'(bus.buf_req), 32'h0);
        chk("ar_gnt",     32'(bus.gnt),     32'h0);
        bus.req = 2'b00;
        step();
        reset         = 1'b1;
        bus.buf_valid = 1'b1;
        step();
        chk("ar_done", 32'(bus.done), 32'h0);
        chk("ar_err",  32'(bus.err),  32'h0);
        // Pointer back to its reset value: consumer 0 wins a tie
        bus.req        = 2'b11;
        bus.buf_vector = 8'hC3;
        step();
        chk("ar_gnt_next", 32'(bus.gnt), 32'h1);
        bus.req = 2'b01;
        step();
        chk("ar_done_next", 32'(bus.done),    32'h1);
        chk("ar_vec_next",  32'(bus.vec_out), 32'hC3);
        bus.req = 2'b00;
        step();

        // Buffer never valid
        bus.buf_valid = 1'b0;
        bus.req       = 2'b11;
        step();
        chk("to_gnt", 32'(bus.gnt), 32'h2);
`ifdef VECTOR_ARB_TIMEOUT_EN
        for (int i = 0; i < 4; i++) begin
            step();
            chk("to_buf_req", 32'(bus.buf_req), 32'h1);
            chk("to_err_low", 32'(bus.err),     32'h0);
        end
        step();
        chk("to_abort_buf_req", 32'(bus.buf_req), 32'h0);
        chk("to_err",           32'(bus.err),     32'h1);
        chk("to_done",          32'(bus.done),    32'h0);
        chk("to_gnt_clr",       32'(bus.gnt),     32'h0);
        step();
        chk("to_err_off", 32'(bus.err), 32'h0);
        chk("to_regnt",   32'(bus.gnt), 32'h1);
        bus.buf_valid = 1'b1;
        step();
        chk("to_regnt_done", 32'(bus.done), 32'h1);
`else
        for (int i = 0; i < TMO + 6; i++) begin
            step();
            chk("nto_buf_req", 32'(bus.buf_req), 32'h1);
            chk("nto_err",     32'(bus.err),     32'h0);
        end
        bus.buf_valid = 1'b1;
        step();
        chk("nto_done", 32'(bus.done), 32'h2);
`endif
        bus.req = 2'b00;
        step();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vector_arbiter.md
VECTOR_ARBITER -- requirements
Module: vector_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 64, SHALL give the maximum cycles spent in REQ before abort (range 1-255).
REQ-002 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 req  input  2  SHALL be the per-consumer vector request, bit N for consumer N, held high until done[N].
REQ-005 buf_req  output  1  SHALL be the request to the shared vector buffer.
REQ-006 buf_vector  input  8  SHALL be the vector from the buffer, qualified by buf_valid.
REQ-007 buf_valid  input  1  SHALL mark buf_vector as valid.
REQ-008 gnt  output  2  SHALL be the one-hot grant, or 0 when idle.
REQ-009 vec_out  output  8  SHALL be the registered vector delivered to the granted consumer.
REQ-010 done  output  2  SHALL pulse bit N for exactly one cycle when vec_out is valid for consumer N.
REQ-011 err  output  1  SHALL pulse for one cycle on a timeout abort.

Function
REQ-012 FSM states SHALL be IDLE, REQ and DELIVER; there SHALL be no other reachable state.
REQ-013 IDLE with req==0 SHALL remain in IDLE, with buf_req=0 and gnt=0.
REQ-014 IDLE with req!=0 SHALL register gnt and enter REQ on the next edge.
REQ-015 Arbitration SHALL be round-robin: single request wins; both set -> the consumer not granted last wins.
REQ-016 A last-grant pointer SHALL update only on entry to REQ.
REQ-017 In REQ, buf_req SHALL be 1 and gnt SHALL stay stable.
REQ-018 A transfer SHALL occur on the edge where buf_req==1 and buf_valid==1.
REQ-019 On transfer, the block SHALL capture buf_vector into vec_out, enter DELIVER and drive buf_req=0 in the next cycle.
REQ-020 In DELIVER, done[gnt] SHALL be 1 for one cycle, vec_out SHALL be valid, and the FSM SHALL return to IDLE and clear gnt.
REQ-021 Minimum latency SHALL be: req sampled at edge 0 -> buf_req high after edge 1 -> done high after edge 2, when buf_valid is already 1.
REQ-022 vec_out SHALL hold its last value outside DELIVER.
REQ-023 buf_valid outside REQ SHALL be ignored.
REQ-024 Deasserting the granted req bit during REQ SHALL NOT abort: the transfer completes and done still pulses.
REQ-025 New requests arriving during REQ/DELIVER SHALL wait until the next IDLE.

Reset
REQ-026 reset low SHALL immediately force IDLE, buf_req=0, gnt=0, done=0, err=0, vec_out=8'h00, last-grant pointer=1 (consumer 0 first), timeout counter=0.
REQ-027 Reset mid-REQ SHALL drop buf_req asynchronously; no done or err SHALL follow.
REQ-028 After reset release, operation SHALL resume from IDLE on the first clock edge.

Configuration
REQ-029 With macro VECTOR_ARB_TIMEOUT_EN defined, an 8-bit counter SHALL count cycles in REQ.
REQ-030 When that counter reaches TIMEOUT without a transfer, the FSM SHALL return to IDLE with err pulsed one cycle, buf_req=0, no done, and the pointer advanced.
REQ-031 The counter SHALL clear on entry to REQ.
REQ-032 Without VECTOR_ARB_TIMEOUT_EN, REQ SHALL wait indefinitely and err SHALL be tied to 0; no counter logic SHALL be built.

Verification
REQ-033 req=2'b01, buf_valid=1, buf_vector=8'hA5 -> gnt=01 after 1 edge, done=01 with vec_out=A5 after 2 edges, IDLE after 3 edges.
REQ-034 req=2'b11 held for 4 transfers -> grant order 0,1,0,1; each done one cycle wide.
REQ-035 req=2'b10, buf_valid delayed 10 cycles -> buf_req high for 11 cycles, then done=10; req change to 01 during the wait is ignored.
REQ-036 reset pulled low in REQ -> buf_req=0 immediately; after release, no done or err; next req=01 is granted to consumer 0.
REQ-037 VECTOR_ARB_TIMEOUT_EN defined, TIMEOUT=5, buf_valid=0 -> buf_req high for 5 cycles, then err pulses once, done stays 0, and a pending req=11 is next granted to the other consumer.
